// File: rtl/fpadd_arbiter.sv
// fpadd_arbiter: shares one pipelined fpadder between NUM_REQ requesters.
//
// A round-robin arbiter picks at most one valid requester per cycle, the
// winning operands are registered into the adder's inputs, and a tag pipe
// of {valid, id} (PIPE_LATENCY deep) travels alongside the adder so that each
// result can be returned to the requester that issued it.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset (the
//                             attached adder shares rst)
//   req_valid/req_ready       per-requester handshake (ready is one-hot/zero)
//   req_a/req_b/req_subtract  packed per-requester operands, slice i at
//                             [i*FLOAT_WIDTH +: FLOAT_WIDTH]
//   drain                     blocks new grants while high
//   fpa_*                     adder operand/result interface
//   resp_valid/id/data/flags  registered result, no backpressure
//   inflight, idle            issued-but-not-returned count, inflight == 0
//   tag_error                 sticky: tag pipe and adder valid_out disagreed
//
// Optional: define FPADD_ARB_STATS_EN to add stat_issued,
// stat_conflict_cycles and stat_per_req_grants (saturating counters).

module fpadd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int FLOAT_WIDTH    = EXPONENT_WIDTH + MANTISSA_WIDTH + 1,
  parameter int PIPE_LATENCY   = 7,
  parameter int ID_WIDTH       = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*FLOAT_WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*FLOAT_WIDTH-1:0]     req_b,
  input  logic [NUM_REQ-1:0]                 req_subtract,
  input  logic                               drain,
  output logic [FLOAT_WIDTH-1:0]             fpa_a,
  output logic [FLOAT_WIDTH-1:0]             fpa_b,
  output logic                               fpa_subtract,
  output logic                               fpa_valid_in,
  input  logic [FLOAT_WIDTH-1:0]             fpa_out,
  input  logic                               fpa_valid_out,
  input  logic [2:0]                         fpa_flags,
  output logic                               resp_valid,
  output logic [ID_WIDTH-1:0]                resp_id,
  output logic [FLOAT_WIDTH-1:0]             resp_data,
  output logic [2:0]                         resp_flags,
  output logic [$clog2(PIPE_LATENCY+2)-1:0]  inflight,
  output logic                               idle,
  output logic                               tag_error
`ifdef FPADD_ARB_STATS_EN
  ,
  output logic [31:0]                        stat_issued,
  output logic [31:0]                        stat_conflict_cycles,
  output logic [NUM_REQ*16-1:0]              stat_per_req_grants
`endif
);

  localparam int CNT_W = $clog2(PIPE_LATENCY+2);

  // First valid requester at or after pointer p, with wrap-around.
  // Walking downward lets the lowest offset overwrite the others.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [ID_WIDTH-1:0] p);
    logic [NUM_REQ-1:0] g;
    int idx;
    g = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (v[ID_WIDTH'(idx)]) begin
        g = '0;
        g[ID_WIDTH'(idx)] = 1'b1;
      end
    end
    return g;
  endfunction

  // ---------------------------------------------------------------- state
  logic [ID_WIDTH-1:0]                        ptr_q, ptr_d;
  logic                                       vin_q, vin_d;
  logic [FLOAT_WIDTH-1:0]                     a_q, a_d, b_q, b_d;
  logic                                       sub_q, sub_d;
  logic [ID_WIDTH-1:0]                        iss_id_q, iss_id_d;
  logic [PIPE_LATENCY-1:0]                    tag_v_q, tag_v_d;
  logic [PIPE_LATENCY-1:0][ID_WIDTH-1:0]      tag_id_q, tag_id_d;
  logic                                       resp_valid_q, resp_valid_d;
  logic [ID_WIDTH-1:0]                        resp_id_q, resp_id_d;
  logic [FLOAT_WIDTH-1:0]                     resp_data_q, resp_data_d;
  logic [2:0]                                 resp_flags_q, resp_flags_d;
  logic [CNT_W-1:0]                           inflight_q, inflight_d;
  logic                                       tag_error_q, tag_error_d;

  // ---------------------------------------------------------------- arbiter
  logic [NUM_REQ-1:0]     grant;
  logic                   xfer;
  logic [ID_WIDTH-1:0]    grant_id;
  logic [FLOAT_WIDTH-1:0] sel_a, sel_b;
  logic                   sel_sub;
  logic                   tag_valid;
  logic [ID_WIDTH-1:0]    tag_id;
  logic                   resp_fire;

  always_comb begin
    grant = '0;
    if (!rst && !drain) grant = rr_pick(req_valid, ptr_q);
    xfer     = |(grant & req_valid);
    grant_id = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_sub  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = ID_WIDTH'(i);
        sel_a    = req_a[i*FLOAT_WIDTH +: FLOAT_WIDTH];
        sel_b    = req_b[i*FLOAT_WIDTH +: FLOAT_WIDTH];
        sel_sub  = req_subtract[i];
      end
    end
  end

  assign req_ready = grant;
  assign tag_valid = tag_v_q[PIPE_LATENCY-1];
  assign tag_id    = tag_id_q[PIPE_LATENCY-1];
  // A response needs both sides to agree; a disagreement only raises tag_error.
  assign resp_fire = tag_valid && fpa_valid_out;

  // ---------------------------------------------------------------- next state
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (grant_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_id + ID_WIDTH'(1);

    // Issue register: operands hold when nothing is issued.
    vin_d    = xfer;
    a_d      = xfer ? sel_a    : a_q;
    b_d      = xfer ? sel_b    : b_q;
    sub_d    = xfer ? sel_sub  : sub_q;
    iss_id_d = xfer ? grant_id : iss_id_q;

    // Tag pipe is fed from the issue register, so its tail lines up with
    // the adder's valid_out.
    tag_v_d     = tag_v_q;
    tag_id_d    = tag_id_q;
    tag_v_d[0]  = vin_q;
    tag_id_d[0] = iss_id_q;
    for (int k = 1; k < PIPE_LATENCY; k++) begin
      tag_v_d[k]  = tag_v_q[k-1];
      tag_id_d[k] = tag_id_q[k-1];
    end

    resp_valid_d = resp_fire;
    resp_id_d    = resp_fire ? tag_id    : resp_id_q;
    resp_data_d  = resp_fire ? fpa_out   : resp_data_q;
    resp_flags_d = resp_fire ? fpa_flags : resp_flags_q;

    tag_error_d = tag_error_q | (tag_valid != fpa_valid_out);

    inflight_d = inflight_q;
    if (xfer && !resp_fire)      inflight_d = inflight_q + CNT_W'(1);
    else if (!xfer && resp_fire) inflight_d = inflight_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      vin_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      iss_id_q     <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_flags_q <= '0;
      inflight_q   <= '0;
      tag_error_q  <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      vin_q        <= vin_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sub_q        <= sub_d;
      iss_id_q     <= iss_id_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_flags_q <= resp_flags_d;
      inflight_q   <= inflight_d;
      tag_error_q  <= tag_error_d;
    end
  end

  assign fpa_valid_in = vin_q;
  assign fpa_a        = a_q;
  assign fpa_b        = b_q;
  assign fpa_subtract = sub_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_data    = resp_data_q;
  assign resp_flags   = resp_flags_q;
  assign inflight     = inflight_q;
  assign idle         = (inflight_q == '0);
  assign tag_error    = tag_error_q;

`ifdef FPADD_ARB_STATS_EN
  // ---------------------------------------------------------------- stats
  logic [31:0]              st_iss_q, st_iss_d;
  logic [31:0]              st_conf_q, st_conf_d;
  logic [NUM_REQ-1:0][15:0] st_grant_q, st_grant_d;

  always_comb begin
    st_iss_d   = st_iss_q;
    st_conf_d  = st_conf_q;
    st_grant_d = st_grant_q;
    if (xfer && st_iss_q != '1) st_iss_d = st_iss_q + 32'd1;
    // More than one bit set: clearing the lowest set bit leaves something.
    if ((|(req_valid & (req_valid - NUM_REQ'(1)))) && st_conf_q != '1)
      st_conf_d = st_conf_q + 32'd1;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i] && st_grant_q[i] != '1) st_grant_d[i] = st_grant_q[i] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_iss_q   <= '0;
      st_conf_q  <= '0;
      st_grant_q <= '0;
    end else begin
      st_iss_q   <= st_iss_d;
      st_conf_q  <= st_conf_d;
      st_grant_q <= st_grant_d;
    end
  end

  assign stat_issued          = st_iss_q;
  assign stat_conflict_cycles = st_conf_q;
  assign stat_per_req_grants  = st_grant_q;
`endif

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Self-checking bench for fpadd_arbiter: a table of grant vectors, directed
// corner sequences, and a randomized phase. A stub adder with the same
// latency sits on the fpa_* port; a queue-based reference model predicts
// grants, responses, inflight, idle and tag_error every cycle.

module tb_fpadd_arbiter;
  localparam int NR = 4;
  localparam int FW = 32;
  localparam int L  = 7;
  localparam int IW = 2;
  localparam int CW = $clog2(L+2);

  logic clk = 1'b0;
  logic rst, drain, force_vo;
  logic [NR-1:0]    req_valid, req_ready, req_sub;
  logic [NR*FW-1:0] req_a, req_b;
  logic [FW-1:0]    fpa_a, fpa_b, fpa_out;
  logic             fpa_subtract, fpa_valid_in, fpa_valid_out;
  logic [2:0]       fpa_flags, resp_flags;
  logic             resp_valid, idle, tag_error;
  logic [IW-1:0]    resp_id;
  logic [FW-1:0]    resp_data;
  logic [CW-1:0]    inflight;
`ifdef FPADD_ARB_STATS_EN
  logic [31:0]      stat_issued, stat_conflict_cycles;
  logic [NR*16-1:0] stat_per_req_grants;
`endif

  fpadd_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_subtract(req_sub), .drain(drain),
    .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_subtract(fpa_subtract),
    .fpa_valid_in(fpa_valid_in), .fpa_out(fpa_out), .fpa_valid_out(fpa_valid_out),
    .fpa_flags(fpa_flags), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_data(resp_data), .resp_flags(resp_flags), .inflight(inflight),
    .idle(idle), .tag_error(tag_error)
`ifdef FPADD_ARB_STATS_EN
    , .stat_issued(stat_issued), .stat_conflict_cycles(stat_conflict_cycles),
    .stat_per_req_grants(stat_per_req_grants)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- float helpers
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (e <= 0)   return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hff, 23'd0};
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic s);
    return r2f(s ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
  endfunction

  function automatic logic [2:0] fflg(input logic [31:0] a, input logic [31:0] b, input logic s);
    return {a[31] ^ b[31], s, a[0] ^ b[0]};
  endfunction

  // ---------------------------------------------------------------- stub adder
  logic        pv [L];
  logic [31:0] pd [L];
  logic [2:0]  pf [L];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < L; k++) pv[k] <= 1'b0;
    end else begin
      pv[0] <= fpa_valid_in;
      pd[0] <= fadd(fpa_a, fpa_b, fpa_subtract);
      pf[0] <= fflg(fpa_a, fpa_b, fpa_subtract);
      for (int k = 1; k < L; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
        pf[k] <= pf[k-1];
      end
    end
  end
  assign fpa_valid_out = pv[L-1] | force_vo;
  assign fpa_out       = pd[L-1];
  assign fpa_flags     = pf[L-1];

  // ---------------------------------------------------------------- reference model
  typedef struct { int due; int id; logic [31:0] data; logic [2:0] flags; } exp_t;
  exp_t          q[$];
  int            m_ptr = 0;
  logic          m_tagerr = 1'b0;
  logic [NR-1:0] last_xfer = '0;

  always @(negedge clk) begin
    logic [NR-1:0] g;
    int   gi;
    logic tag_next;
    exp_t e;
    g  = '0;
    gi = -1;
    if (!rst && !drain)
      for (int k = 0; k < NR; k++)
        if (gi < 0 && req_valid[(m_ptr + k) % NR]) gi = (m_ptr + k) % NR;
    if (gi >= 0) g[gi] = 1'b1;
    chk("mon_ready", req_ready, g);

    if (q.size() > 0 && q[0].due == cyc) begin
      chk("mon_resp_valid", resp_valid, 1);
      chk("mon_resp_id",    resp_id,    q[0].id);
      chk("mon_resp_data",  resp_data,  q[0].data);
      chk("mon_resp_flags", resp_flags, q[0].flags);
      void'(q.pop_front());
    end else begin
      chk("mon_resp_valid", resp_valid, 0);
    end
    chk("mon_inflight",  inflight,  q.size());
    chk("mon_idle",      idle,      q.size() == 0);
    chk("mon_tag_error", tag_error, m_tagerr);

    // An op is in the adder's last stage this cycle iff its response is due next cycle.
    tag_next = (q.size() > 0 && q[0].due == cyc + 1);
    if (force_vo && !tag_next) m_tagerr = 1'b1;

    last_xfer = g;
    if (gi >= 0) begin
      e.due   = cyc + L + 2;
      e.id    = gi;
      e.data  = fadd(req_a[gi*FW +: FW], req_b[gi*FW +: FW], req_sub[gi]);
      e.flags = fflg(req_a[gi*FW +: FW], req_b[gi*FW +: FW], req_sub[gi]);
      q.push_back(e);
      m_ptr = (gi + 1) % NR;
    end
    if (rst) begin
      q.delete();
      m_ptr    = 0;
      m_tagerr = 1'b0;
    end
  end

  // ---------------------------------------------------------------- drivers
  function automatic logic [31:0] rnd_f();
    logic [7:0] e;
    e = 8'(120 + $urandom % 15);
    return {1'($urandom % 2), e, 23'($urandom)};
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_a[i*FW +: FW] = a;
    req_b[i*FW +: FW] = b;
    req_sub[i]        = s;
  endtask

  task automatic new_ops(input int i);
    set_op(i, rnd_f(), rnd_f(), 1'($urandom % 2));
  endtask

  // Fresh operands only where the requester is not holding a pending op.
  task automatic refresh();
    for (int i = 0; i < NR; i++)
      if (!req_valid[i] || last_xfer[i]) new_ops(i);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; drain = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!idle && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle", idle, 1);
    step();
  endtask

  typedef struct { logic [NR-1:0] v; logic d; logic [NR-1:0] exp; } vec_t;
  vec_t tbl[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   cnt, first, bad, lat;
    logic ok, found;
    logic [31:0] dat;
    logic [NR-1:0] one;

    tbl[0]  = '{4'b1111, 1'b0, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0010};
    tbl[2]  = '{4'b0001, 1'b0, 4'b0001};
    tbl[3]  = '{4'b1001, 1'b0, 4'b1000};
    tbl[4]  = '{4'b1001, 1'b0, 4'b0001};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0000};
    tbl[6]  = '{4'b0000, 1'b0, 4'b0000};
    tbl[7]  = '{4'b0100, 1'b0, 4'b0100};
    tbl[8]  = '{4'b0110, 1'b0, 4'b0010};
    tbl[9]  = '{4'b1111, 1'b0, 4'b0100};
    tbl[10] = '{4'b1111, 1'b0, 4'b1000};

    rst = 1'b1; drain = 1'b0; force_vo = 1'b0;
    req_valid = '0; req_sub = '0; req_a = '0; req_b = '0;
    step(); step();

    // Reset state
    @(negedge clk);
    chk("rst_fpa_valid_in", fpa_valid_in, 0);
    chk("rst_fpa_a",        fpa_a,        0);
    chk("rst_fpa_b",        fpa_b,        0);
    chk("rst_fpa_subtract", fpa_subtract, 0);
    chk("rst_resp_valid",   resp_valid,   0);
    chk("rst_resp_id",      resp_id,      0);
    chk("rst_resp_data",    resp_data,    0);
    chk("rst_resp_flags",   resp_flags,   0);
    chk("rst_inflight",     inflight,     0);
    chk("rst_tag_error",    tag_error,    0);
    chk("rst_idle",         idle,         1);
    step();
    rst = 1'b0;

    // Grant table
    for (int r = 0; r < 11; r++) begin
      refresh();
      req_valid = tbl[r].v;
      drain     = tbl[r].d;
      @(negedge clk);
      chk($sformatf("tbl_ready_%0d", r), req_ready, tbl[r].exp);
      step();
    end
    req_valid = '0; drain = 1'b0;
    wait_idle();

    // Single op from requester 2
    do_reset();
    set_op(2, 32'h3F800000, 32'h40000000, 1'b0);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k;
        chk("single_id",   resp_id,   2);
        chk("single_data", resp_data, 32'h40400000);
        break;
      end
    end
    chk("single_latency", lat, L + 2);
    step();
    wait_idle();

    // Round robin with all requesters valid
    do_reset();
    one = 1; cnt = 0; first = -1; ok = 1'b1;
    for (int k = 0; k < 26; k++) begin
      if (k < 12) begin refresh(); req_valid = '1; end
      else req_valid = '0;
      @(negedge clk);
      if (k < 12) chk("rr_grant", req_ready, one << (k % NR));
      if (resp_valid) begin
        if (first < 0) first = k;
        if (k != first + cnt || int'(resp_id) != cnt % NR) ok = 1'b0;
        cnt++;
      end
      step();
    end
    chk("rr_resp_count", cnt, 12);
    chk("rr_resp_order", ok, 1);
    wait_idle();

    // Subtract and pointer wrap
    do_reset();
    new_ops(2);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("wrap_setup", req_ready, 4'b0100);
    step();
    set_op(3, 32'h3F800000, 32'h3F800000, 1'b0);
    set_op(0, 32'h40400000, 32'h3F800000, 1'b1);
    req_valid = 4'b1001;
    @(negedge clk);
    chk("wrap_grant3", req_ready, 4'b1000);
    step();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("wrap_grant0", req_ready, 4'b0001);
    step();
    req_valid = '0;
    found = 1'b0; dat = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid && resp_id == 2'd0) begin found = 1'b1; dat = resp_data; break; end
    end
    chk("wrap_resp0_seen", found, 1);
    chk("wrap_resp0_data", dat, 32'h40000000);
    step();
    refresh();
    req_valid = '1;
    @(negedge clk);
    chk("wrap_ptr1", req_ready, 4'b0010);
    step();
    req_valid = '0;
    wait_idle();

    // Drain with 5 ops in flight
    do_reset();
    for (int k = 0; k < 5; k++) begin
      refresh();
      req_valid = '1;
      step();
    end
    drain = 1'b1;
    @(negedge clk);
    chk("drain_ready",    req_ready, 0);
    chk("drain_inflight", inflight,  5);
    cnt = 0; bad = 0;
    for (int k = 0; k < 30; k++) begin
      if (req_ready != '0) bad++;
      if (resp_valid) cnt++;
      if (idle) break;
      @(negedge clk);
    end
    chk("drain_resp_count", cnt, 5);
    chk("drain_ready_low",  bad, 0);
    chk("drain_idle",       idle, 1);
    step();
    drain = 1'b0; req_valid = '0;

    // Reset with 4 ops in flight
    do_reset();
    for (int k = 0; k < 4; k++) begin
      refresh();
      req_valid = '1;
      step();
    end
    do_reset();
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (resp_valid) bad++;
    end
    chk("rstmid_no_resp",   bad,       0);
    chk("rstmid_inflight",  inflight,  0);
    chk("rstmid_tag_error", tag_error, 0);
    step();
    refresh();
    req_valid = '1;
    @(negedge clk);
    chk("rstmid_ptr0", req_ready, 4'b0001);
    step();
    req_valid = '0;
    wait_idle();

    // Spurious adder valid_out
    force_vo = 1'b1;
    @(negedge clk);
    step();
    force_vo = 1'b0;
    @(negedge clk);
    chk("tag_err_set",    tag_error,  1);
    chk("tag_resp_quiet", resp_valid, 0);
    repeat (3) @(negedge clk);
    chk("tag_err_sticky", tag_error, 1);
    step();
    do_reset();
    @(negedge clk);
    chk("tag_err_cleared", tag_error, 0);
    step();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && !last_xfer[i]) begin
          if ($urandom % 10 == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = 1'($urandom % 2);
          new_ops(i);
        end
      end
      drain = ($urandom % 12 == 0);
      step();
    end
    req_valid = '0; drain = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fpadd_arbiter.md
Name: fpadd_arbiter

Overview:
- Shares one pipelined fpadder between NUM_REQ requesters using round-robin arbitration.
- Issues at most one operation per cycle into the adder and tags each issued operation with its requester ID.
- Returns each result to the requester that issued it, with the adder's flags.
- Sits between the FPU front-end ports (issue stages) and a single fpadder instance.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- EXPONENT_WIDTH, 8, float exponent width, passed through to the adder operand/result width
- MANTISSA_WIDTH, 23, float mantissa width
- FLOAT_WIDTH, EXPONENT_WIDTH+MANTISSA_WIDTH+1, operand/result width
- PIPE_LATENCY, 7, cycles from adder valid_in to adder valid_out
- ID_WIDTH, $clog2(NUM_REQ), requester tag width

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  NUM_REQ  per-requester operation valid
- req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  input  NUM_REQ*FLOAT_WIDTH  packed operand A; requester i occupies slice [i*FLOAT_WIDTH +: FLOAT_WIDTH]
- req_b  input  NUM_REQ*FLOAT_WIDTH  packed operand B, same packing
- req_subtract  input  NUM_REQ  per-requester subtract select
- drain  input  1  when high, no new grants are made
- fpa_a, fpa_b  output  FLOAT_WIDTH  adder operands
- fpa_subtract  output  1  adder subtract
- fpa_valid_in  output  1  adder valid_in
- fpa_out  input  FLOAT_WIDTH  adder result
- fpa_valid_out  input  1  adder valid_out
- fpa_flags  input  3  {invalid, overflow, underflow} from adder
- resp_valid  output  1  result valid
- resp_id  output  ID_WIDTH  destination requester
- resp_data  output  FLOAT_WIDTH  result
- resp_flags  output  3  flags captured with the result
- inflight  output  $clog2(PIPE_LATENCY+2)  operations issued but not yet returned
- idle  output  1  no operation pending in the arbiter or the adder
- tag_error  output  1  sticky protocol error flag

Behaviour:
- Reset (synchronous): the following are all 0 on the cycle after rst is sampled high:
  - outputs: fpa_valid_in, resp_valid, resp_id, resp_data, resp_flags, inflight, tag_error
  - internal state: all tag-pipe valid bits; RR pointer = 0
  - fpa_a, fpa_b and fpa_subtract are cleared to 0.
  - idle = 1.
- rst must also reset the attached adder in the same cycle. A reset mid-operation discards all in-flight tags; no responses are produced for operations issued before reset.
- Grant (combinational):
  - If drain = 0 and rst = 0, grant the first requester with req_valid = 1, searching from the RR pointer upward with wrap-around.
  - req_ready = one-hot grant; req_ready = 0 while drain or rst is high.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - A requester holds valid and its operands stable until ready.
  - Deasserting valid without a transfer is legal; no grant is lost.
- RR pointer: on a transfer from requester i, pointer <= (i+1) mod NUM_REQ. With no transfer the pointer holds.
- Issue register: on a transfer, the next cycle has fpa_valid_in = 1 with fpa_a/fpa_b/fpa_subtract = the granted requester's values. Otherwise fpa_valid_in = 0 and the operands hold.
- Tag pipe:
  - PIPE_LATENCY-deep shift register of {valid, id}, loaded from the issue register.
  - Its output is aligned with fpa_valid_out.
- Response:
  - resp_valid is registered: it equals tag_valid && fpa_valid_out from the prior cycle, with resp_id = tag id and resp_data/resp_flags = fpa_out/fpa_flags captured in that same cycle.
  - Latency from transfer to resp_valid = PIPE_LATENCY+2 (9 at default).
  - resp_valid has no backpressure; requesters must sink responses.
- tag_error: set and held until rst when tag_valid != fpa_valid_out in any cycle. resp_valid is still generated only from the AND.
- Throughput: one transfer per cycle sustained; full bandwidth with NUM_REQ requesters all valid, each granted once every NUM_REQ cycles.
- inflight counter:
  - Increments on a transfer and decrements on resp_valid generation; both in the same cycle leaves it unchanged.
  - It never exceeds PIPE_LATENCY+1.
- idle = (inflight == 0).
- drain: asserting drain mid-stream stops new grants the same cycle. In-flight operations complete normally and idle rises after the last response.

Optional Feature:
- Macro: FPADD_ARB_STATS_EN.
- When defined, three additional outputs are present: stat_issued (32b), stat_conflict_cycles (32b) and stat_per_req_grants (NUM_REQ*16b).
  - stat_issued counts transfers.
  - stat_conflict_cycles counts cycles with more than one req_valid high.
  - stat_per_req_grants holds per-requester grant counts; the counters saturate.
  - All are cleared by rst.
- When not defined, these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Single op: requester 2 sends a=0x3F800000, b=0x40000000, subtract=0 → req_ready[2] high the same cycle; resp_valid 9 cycles later with id=2, data=0x40400000.
- Round-robin: all 4 requesters valid continuously from reset → grants 0,1,2,3,0,1... and responses return in the same id order, one per cycle, with no gaps.
- Subtract and wrap: pointer=3, only requesters 3 and 0 valid, requester 0 sends 3.0−1.0 → grant 3 then 0; requester 0 receives 0x40000000 and the pointer ends at 1.
- Drain: drain asserted with 5 ops in flight → req_ready=0 while drained; exactly 5 responses follow, inflight counts 5→0, then idle=1.
- Reset mid-flight: rst for 1 cycle with 4 ops in flight → no resp_valid afterwards, inflight=0, tag_error=0, pointer=0.
- Tag check: force fpa_valid_out=1 with no tag in flight → tag_error=1 sticky, resp_valid stays 0.
